// File: rtl/fifo_read_drain_pkg.sv
// Shared constants for the dual-clock fifo and its read-side drain.
package fifo_read_drain_pkg;

    localparam int DSIZE_DEF = 16;
    localparam int ASIZE_DEF = 4;
    localparam int BURST_DEF = 4;
    localparam int CNT_W_DEF = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry {data, last} register buffer with a load port and a valid/ready output.
module fifo_skid_buf
    import fifo_read_drain_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DSIZE-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_last,
    output logic             valid,
    output logic             full,
    output logic             accept
);

    logic [DSIZE-1:0] data_r [2];
    logic [1:0]       last_r;
    logic             head_r;
    logic             tail_r;
    logic [1:0]       cnt_r;
    logic             accept_s;

    assign accept_s = (cnt_r != 2'd0) && ready;

    // Buffer storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r[0] <= {DSIZE{1'b0}};
            data_r[1] <= {DSIZE{1'b0}};
            last_r    <= 2'b00;
            head_r    <= 1'b0;
            tail_r    <= 1'b0;
            cnt_r     <= 2'd0;
        end else begin
            if (load) begin
                data_r[tail_r] <= load_data;
                last_r[tail_r] <= load_last;
                tail_r         <= ~tail_r;
            end
            if (accept_s) begin
                head_r <= ~head_r;
            end
            cnt_r <= cnt_r + {1'b0, load} - {1'b0, accept_s};
        end
    end

    // Head entry is presented directly from its register.
    assign out_data = data_r[head_r];
    assign out_last = last_r[head_r];
    assign valid    = (cnt_r != 2'd0);
    assign full     = (cnt_r == 2'd2);
    assign accept   = accept_s;

endmodule

// File: rtl/fifo_read_drain.sv
// Read-side drain: pops the fifo into a skid buffer, tags burst boundaries, counts transfers.
module fifo_read_drain
    import fifo_read_drain_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int BURST = BURST_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             r_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BEAT_W = (BURST > 1) ? clog2(BURST) : 1;

    logic [BEAT_W-1:0] beat_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic              full_s;
    logic              accept_s;
    logic              last_s;
    logic              r_en_s;

    // No m_ready term here, so the pop decision never waits on downstream.
    assign r_en_s = rrst_n && !rempty && !full_s;
    assign last_s = (beat_r == BEAT_W'(BURST - 1));
    assign r_en   = r_en_s;

    fifo_skid_buf #(
        .DSIZE (DSIZE)
    ) u_buf (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .load      (r_en_s),
        .load_data (rdata),
        .load_last (last_s),
        .ready     (m_ready),
        .out_data  (m_data),
        .out_last  (m_last),
        .valid     (m_valid),
        .full      (full_s),
        .accept    (accept_s)
    );

    // Position of the next popped word within its burst.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (r_en_s) begin
            beat_r <= last_s ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
        end else begin
            beat_r <= beat_r;
        end
    end

    // Accepted-transfer counter, wraps naturally.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            word_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            word_cnt_r <= word_cnt_r + CNT_W'(1);
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_fifo_read_drain.sv
// Randomized scoreboard bench for fifo_read_drain against a queue-based fifo/stream model.
module tb_fifo_read_drain;

    localparam int DSIZE = 16;
    localparam int BURST = 4;
    localparam int CNT_W = 4;

    logic             rclk = 1'b0;
    logic             rrst_n = 1'b0;
    logic             rempty = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             m_ready = 1'b0;
    logic             r_en;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
    logic [CNT_W-1:0] word_cnt;

    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE:0]   exp_q[$];
    bit               gate_empty = 1'b0;
    bit               rst_prev = 1'b0;
    int               pop_idx = 0;
    int               pop_count = 0;
    int               wc_model = 0;
    int               tests = 0;
    int               fails = 0;

    fifo_read_drain #(
        .DSIZE (DSIZE),
        .BURST (BURST),
        .CNT_W (CNT_W)
    ) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rempty   (rempty),
        .rdata    (rdata),
        .r_en     (r_en),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .word_cnt (word_cnt)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Fifo model drives rempty/rdata at negedge; monitor checks and advances the model.
    always begin
        logic exp_valid;
        logic exp_ren;
        logic [DSIZE:0] w;
        @(negedge rclk);
        rempty = gate_empty || (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_ren   = rrst_n && !rempty && (exp_q.size() < 2);
        chk("r_en", 32'(r_en), 32'(exp_ren));
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("word_cnt", 32'(word_cnt), 32'(wc_model % (1 << CNT_W)));
        if (exp_valid) begin
            w = exp_q[0];
            chk("m_data", 32'(m_data), 32'(w[DSIZE-1:0]));
            chk("m_last", 32'(m_last), 32'(w[DSIZE]));
        end
        if (!rst_prev) begin
            chk("rst_m_data", 32'(m_data), 32'h0);
            chk("rst_m_last", 32'(m_last), 32'h0);
        end
        if (!rrst_n) begin
            exp_q.delete();
            pop_idx  = 0;
            wc_model = 0;
        end else begin
            if (exp_valid && m_ready) begin
                void'(exp_q.pop_front());
                wc_model = wc_model + 1;
            end
            if (exp_ren) begin
                w[DSIZE-1:0] = fifo_q.pop_front();
                w[DSIZE]     = ((pop_idx % BURST) == BURST - 1);
                exp_q.push_back(w);
                pop_idx   = pop_idx + 1;
                pop_count = pop_count + 1;
            end
        end
        rst_prev = rrst_n;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        fifo_q.delete();
        rrst_n = 1'b0;
        cyc(n);
        rrst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            cyc(1);
            k = k + 1;
        end
        cyc(1);
        tests = tests + 1;
        if (k >= budget) begin
            fails = fails + 1;
            $display("FAIL %s_timeout: %0d words left, required 0", name, fifo_q.size() + exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with data waiting and downstream ready; then plain 4-word burst.
        m_ready = 1'b1;
        fifo_q  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        cyc(2);
        pop_count = 0;
        rrst_n = 1'b1;
        drain("t2", 20);
        chk("t2_pops", 32'(pop_count), 32'd4);
        chk("t2_word_cnt", 32'(word_cnt), 32'd4);

        // Backpressure: only two pops, head held, then everything delivered in order.
        do_reset(1);
        m_ready = 1'b0;
        pop_count = 0;
        for (int i = 0; i < 6; i++) fifo_q.push_back(16'($urandom));
        cyc(12);
        chk("t3_pops_held", 32'(pop_count), 32'd2);
        chk("t3_valid_held", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        drain("t3", 30);
        chk("t3_word_cnt", 32'(word_cnt), 32'd6);

        // Empty fifo with one buffered word: delivered, nothing popped.
        do_reset(1);
        m_ready = 1'b0;
        fifo_q.push_back(16'h5A5A);
        cyc(3);
        gate_empty = 1'b1;
        fifo_q.push_back(16'h6B6B);
        cyc(1);
        pop_count = 0;
        m_ready = 1'b1;
        cyc(4);
        chk("t4_no_pop", 32'(pop_count), 32'd0);
        chk("t4_valid_low", 32'(m_valid), 32'd0);
        gate_empty = 1'b0;
        drain("t4", 20);

        // Reset mid-burst and mid-transfer: buffered words discarded, beat restarts.
        do_reset(1);
        m_ready = 1'b1;
        fifo_q = '{16'hB001, 16'hB002};
        cyc(4);
        m_ready = 1'b0;
        fifo_q = '{16'hB003, 16'hB004};
        cyc(3);
        do_reset(1);
        m_ready = 1'b1;
        fifo_q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        drain("t5", 20);
        chk("t5_word_cnt", 32'(word_cnt), 32'd4);

        // 17 words with m_ready toggling: counter wraps 15 -> 0 and ends at 1.
        do_reset(1);
        for (int i = 0; i < 17; i++) fifo_q.push_back(16'($urandom));
        for (int k = 0; k < 100 && (fifo_q.size() != 0 || exp_q.size() != 0); k++) begin
            m_ready = ~m_ready;
            cyc(1);
        end
        m_ready = 1'b1;
        drain("t6", 10);
        chk("t6_word_cnt", 32'(word_cnt), 32'd1);

        // Random traffic: random arrivals, gaps, backpressure and occasional reset.
        do_reset(1);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) != 0) fifo_q.push_back(16'($urandom));
            m_ready    = ($urandom_range(0, 3) != 0);
            gate_empty = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 150) == 0) begin
                fifo_q.delete();
                rrst_n = 1'b0;
            end else begin
                rrst_n = 1'b1;
            end
            cyc(1);
        end
        rrst_n = 1'b1;
        gate_empty = 1'b0;
        m_ready = 1'b1;
        drain("rand", 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
